icache_refill: RTL and testbench
================================

# icache_refill

Line-fill engine for the instruction cache. On a miss it issues one aligned burst read to the memory bus and assembles the returned words into a full cache line. It then writes that line into the iCache data RAM in one cycle through the RAM's `addr`/`din`/`wen` write port, and signals completion to the miss handler. It is the only writer of the data RAM; the fetch path is its only reader.

## Interface
- `SET_BITS`, default `` `ICACHE_S ``: index width; the RAM has 2**SET_BITS lines.
- `LINE_BITS`, default `` `ICACHE_B ``: byte-offset width; the line holds WORDS = 2**(LINE_BITS-2) 32-bit words.
- `TAG_BITS`, default 32-SET_BITS-LINE_BITS: tag width.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `miss_req`  in  1  refill request, sampled only in IDLE.
- `miss_addr`  in  32  byte address of the missing fetch.
- `busy`  out  1  high whenever state != IDLE.
- `refill_done`  out  1  one-cycle pulse when the line is written.
- `line_tag`  out  TAG_BITS  tag of the line being filled; valid while busy.
- `mem_arvalid`  out  1  burst read request valid.
- `mem_araddr`  out  32  line-aligned burst start address.
- `mem_arlen`  out  8  beats minus one, fixed at WORDS-1.
- `mem_arready`  in  1  memory accepts the request.
- `mem_rvalid`  in  1  read beat valid.
- `mem_rdata`  in  32  read beat data.
- `mem_rlast`  in  1  last-beat marker; informational only.
- `mem_rready`  out  1  engine accepts beats.
- `ram_addr`  out  SET_BITS  data RAM line index.
- `ram_din`  out  WORDS*32  assembled line; word i is at bits [32i+31:32i].
- `ram_wen`  out  1  data RAM write enable.

## Operation
- The FSM has four states: IDLE, ADDR, DATA and WRITE.
- **IDLE:** when `miss_req`=1, latch the following, then go to ADDR.
  - `idx` = miss_addr[LINE_BITS+SET_BITS-1:LINE_BITS]
  - `tag` = miss_addr[31:LINE_BITS+SET_BITS]
  - `base` = {miss_addr[31:LINE_BITS], LINE_BITS'b0}
- **ADDR:**
  - Drive `mem_arvalid`=1, `mem_araddr`=base and `mem_arlen`=WORDS-1.
  - Hold all three stable until `mem_arready`=1; that cycle is the handshake. Then go to DATA with `beat`=0.
- **DATA:**
  - `mem_rready`=1. Each cycle with `mem_rvalid`=1 stores `mem_rdata` into word[beat] and increments `beat`.
  - `beat` is log2(WORDS) bits wide. On the beat accepted with beat==WORDS-1, go to WRITE.
  - Beat count alone ends the burst; `mem_rlast` does not affect control.
- **WRITE:**
  - For one cycle drive `ram_wen`=1, `ram_addr`=idx and `ram_din`=assembled line, and assert `refill_done`=1.
  - Next state is IDLE.
- `miss_req` is ignored while busy; the requester holds it until it sees `refill_done`.
- In IDLE, WRITE's write is never repeated and `ram_wen`=0.
- Word buffer: only the beat being written changes each cycle. Contents are not cleared between refills; every word is overwritten before use.

## Timing
- **Reset values** (state IDLE):
  - busy=0, refill_done=0, mem_arvalid=0, mem_rready=0, ram_wen=0
  - mem_araddr=0, ram_addr=0, line_tag=0, beat=0
  - mem_arlen is a constant WORDS-1.
- **Latency:**
  - `miss_req` is sampled at edge T0, and `mem_arvalid` is high from cycle T0+1.
  - With arready in the first cycle and rvalid on consecutive cycles, the beats land at T0+2 through T0+1+WORDS.
  - ram_wen/refill_done are high in cycle T0+2+WORDS, and busy is low the cycle after.
  - Total minimum latency is WORDS+3 cycles from request to idle.
- **Stalls:** gaps in `mem_rvalid` only stretch DATA; no beat is lost or duplicated.
- **Back-to-back:** a `miss_req` present in the cycle after `refill_done` starts a new refill. There is no dead cycle beyond the return to IDLE.
- **Reset mid-burst:** the next state is IDLE, all outputs take reset values, and no RAM write happens. The memory interface is reset by the same `reset`, so no stale beats arrive.
- **Combinational paths:** `mem_rready` and `mem_arvalid` are decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use SET_BITS=7 and LINE_BITS=5, so WORDS=8.
1. **Basic refill:** miss_addr=0x1FC0_0A64, arready immediate, beats 0xA0..0xA7 back-to-back.
   - Expect araddr=0x1FC0_0A60, arlen=7 and idx=0x53.
   - Expect one ram_wen cycle at T0+10 with ram_din word0=0xA0 … word7=0xA7, refill_done coincident, and busy low at T0+11.
2. **Address stall:** arready held low for 5 cycles.
   - Expect arvalid and araddr stable throughout, exactly one handshake, and completion delayed by 5 cycles.
3. **Data bubbles:** rvalid pattern 1,0,1,1,0,0,1,… for 8 beats.
   - Expect the line assembled in order and exactly one ram_wen.
4. **Ignored request:** pulse miss_req with address 0x0000_1000 during DATA.
   - Expect no effect; ram_addr equals the original idx.
5. **Reset in DATA:** assert reset after beat 3.
   - Expect all outputs at reset values the next cycle, and ram_wen never asserted for that line.
6. **Back-to-back refills:** two misses to idx 0x00 then 0x7F.
   - Expect two writes with correct indices and tags, and the second request starting in the cycle after the first refill_done.

Source files
------------

// File: rtl/icache_refill.sv
// Instruction-cache line-fill engine: one aligned burst read per miss, beats
// assembled into a full line, then a single-cycle write into the data RAM.
`ifndef ICACHE_S
`define ICACHE_S 7
`endif
`ifndef ICACHE_B
`define ICACHE_B 5
`endif

module icache_refill #(
  parameter  int SET_BITS  = `ICACHE_S,
  parameter  int LINE_BITS = `ICACHE_B,
  parameter  int TAG_BITS  = 32 - SET_BITS - LINE_BITS,
  localparam int WORDS     = 2 ** (LINE_BITS - 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  output logic                  busy,
  output logic                  refill_done,
  output logic [TAG_BITS-1:0]   line_tag,
  output logic                  mem_arvalid,
  output logic [31:0]           mem_araddr,
  output logic [7:0]            mem_arlen,
  input  logic                  mem_arready,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rlast,
  output logic                  mem_rready,
  output logic [SET_BITS-1:0]   ram_addr,
  output logic [WORDS*32-1:0]   ram_din,
  output logic                  ram_wen
);

  localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [BEAT_W-1:0]   beat_r;
  logic [SET_BITS-1:0] idx_r;
  logic [TAG_BITS-1:0] tag_r;
  logic [31:0]         base_r;
  logic [31:0]         word_r [WORDS];
  logic                busy_r;
  logic                arvalid_r;
  logic                rready_r;
  logic                wen_r;
  logic                last_beat_s;
  logic                unused_s;

  // The burst length alone ends DATA; rlast and the in-line offset bits are not needed.
  assign unused_s    = ^{mem_rlast, miss_addr[LINE_BITS-1:0]};
  assign last_beat_s = (beat_r == BEAT_W'(WORDS - 1));

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_req) state_s = ST_ADDR;
        else          state_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (mem_arready) state_s = ST_DATA;
        else             state_s = ST_ADDR;
      end
      ST_DATA: begin
        if (mem_rvalid && last_beat_s) state_s = ST_WRITE;
        else                           state_s = ST_DATA;
      end
      ST_WRITE: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register plus state-decoded handshake/status flops (no input-to-output path).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      wen_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy_r    <= (state_s != ST_IDLE);
      arvalid_r <= (state_s == ST_ADDR);
      rready_r  <= (state_s == ST_DATA);
      wen_r     <= (state_s == ST_WRITE);
    end
  end

  // Request latch and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r  <= '0;
      tag_r  <= '0;
      base_r <= 32'h0000_0000;
      beat_r <= '0;
    end else begin
      if (state_r == ST_IDLE && miss_req) begin
        idx_r  <= miss_addr[LINE_BITS+SET_BITS-1:LINE_BITS];
        tag_r  <= miss_addr[31:LINE_BITS+SET_BITS];
        base_r <= {miss_addr[31:LINE_BITS], {LINE_BITS{1'b0}}};
      end
      if (state_r == ST_ADDR && mem_arready) begin
        beat_r <= '0;
      end else if (state_r == ST_DATA && mem_rvalid) begin
        beat_r <= beat_r + BEAT_W'(1);
      end
    end
  end

  // Line buffer is never cleared: every word is rewritten before the line is used.
  always_ff @(posedge clk) begin
    if (state_r == ST_DATA && mem_rvalid) begin
      word_r[beat_r] <= mem_rdata;
    end
  end

  // Flatten the buffer onto the RAM data bus, word i at bits [32i+31:32i].
  always_comb begin
    ram_din = '0;
    for (int i = 0; i < WORDS; i++) begin
      ram_din[32*i +: 32] = word_r[i];
    end
  end

  assign busy        = busy_r;
  assign refill_done = wen_r;
  assign ram_wen     = wen_r;
  assign mem_arvalid = arvalid_r;
  assign mem_rready  = rready_r;
  assign mem_araddr  = base_r;
  assign mem_arlen   = 8'(WORDS - 1);
  assign ram_addr    = idx_r;
  assign line_tag    = tag_r;

endmodule

// File: tb/tb_icache_refill.sv
// Randomized self-checking bench for icache_refill (SET_BITS=7, LINE_BITS=5, 8 words).
module tb_icache_refill;
  localparam int SET_BITS  = 7;
  localparam int LINE_BITS = 5;
  localparam int TAG_BITS  = 20;
  localparam int WORDS     = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                miss_req;
  logic [31:0]         miss_addr;
  logic                busy;
  logic                refill_done;
  logic [TAG_BITS-1:0] line_tag;
  logic                mem_arvalid;
  logic [31:0]         mem_araddr;
  logic [7:0]          mem_arlen;
  logic                mem_arready;
  logic                mem_rvalid;
  logic [31:0]         mem_rdata;
  logic                mem_rlast;
  logic                mem_rready;
  logic [SET_BITS-1:0] ram_addr;
  logic [WORDS*32-1:0] ram_din;
  logic                ram_wen;

  icache_refill #(.SET_BITS(SET_BITS), .LINE_BITS(LINE_BITS)) dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy), .refill_done(refill_done), .line_tag(line_tag),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
    .mem_arready(mem_arready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rlast(mem_rlast), .mem_rready(mem_rready), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_wen(ram_wen)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observations of the most recent refill, filled in by do_refill.
  int                  wen_count, done_count, wen_k, handshakes, data_cycles;
  int                  araddr_bad, arvalid_bad, rready_bad, busy_bad, first_arvalid_k;
  logic                wen_done, busy_after;
  logic [31:0]         hs_araddr;
  logic [7:0]          hs_arlen;
  logic [SET_BITS-1:0] wen_addr;
  logic [TAG_BITS-1:0] wen_tag;
  logic [WORDS*32-1:0] wen_din;
  logic [WORDS*32-1:0] exp_line;
  logic [31:0]         beat_data [WORDS];
  int                  bubble_pat [7] = '{1, 0, 1, 1, 0, 0, 1};

  // Plays requester and memory for one refill. Entered and left on a negedge in an IDLE cycle.
  task automatic do_refill(input logic [31:0] addr, input int ar_stall, input int pmode,
                           input int abort_beats, input bit chain, input logic [31:0] chain_addr,
                           input bit pulse_ignored, input bit rand_rlast, input bit fixed_data);
    int  c, sent;
    bit  phase, v;
    logic [31:0] exp_base;
    wen_count = 0; done_count = 0; wen_k = -1; handshakes = 0; data_cycles = 0;
    araddr_bad = 0; arvalid_bad = 0; rready_bad = 0; busy_bad = 0; first_arvalid_k = -1;
    wen_done = 1'b0; busy_after = 1'b1; hs_araddr = 32'h0; hs_arlen = 8'h0;
    for (int i = 0; i < WORDS; i++) begin
      beat_data[i] = fixed_data ? (32'hA0 + 32'(i)) : $urandom;
      exp_line[32*i +: 32] = beat_data[i];
    end
    exp_base = addr & 32'hFFFF_FFE0;
    miss_req = 1'b1; miss_addr = addr;
    phase = 1'b0; c = 0; sent = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (mem_arvalid && first_arvalid_k < 0) first_arvalid_k = k;
      if (wen_count == 0 && !busy) busy_bad++;
      if (wen_count > 0) begin
        busy_after = busy;
        break;
      end
      if (ram_wen) begin
        wen_count++; wen_k = k; wen_addr = ram_addr; wen_tag = line_tag;
        wen_din = ram_din; wen_done = refill_done;
      end
      if (refill_done) done_count++;
      if (phase && abort_beats > 0 && sent == abort_beats) begin
        reset = 1'b1; miss_req = 1'b0; mem_rvalid = 1'b0; mem_arready = 1'b0; mem_rlast = 1'b0;
        return;
      end
      if (!phase) begin
        if (!mem_arvalid) arvalid_bad++;
        else if (mem_araddr !== exp_base || mem_arlen !== 8'd7) araddr_bad++;
        mem_arready = (c >= ar_stall);
        if (mem_arready && mem_arvalid) begin
          hs_araddr = mem_araddr; hs_arlen = mem_arlen; handshakes++; phase = 1'b1;
        end
        c++;
        mem_rvalid = 1'b0; mem_rlast = 1'b0;
      end else begin
        if (mem_arvalid) arvalid_bad++;
        mem_arready = 1'($urandom_range(0, 1));
        if (sent < WORDS) begin
          if (!mem_rready) rready_bad++;
          if (pmode == 0)      v = 1'b1;
          else if (pmode == 1) v = (bubble_pat[data_cycles % 7] == 1);
          else                 v = 1'($urandom_range(0, 1));
          data_cycles++;
          mem_rvalid = v;
          mem_rdata  = v ? beat_data[sent] : $urandom;
          mem_rlast  = rand_rlast ? 1'($urandom_range(0, 1)) : (v && sent == WORDS - 1);
          if (v) sent++;
        end else begin
          mem_rvalid = 1'b0; mem_rlast = 1'b0;
        end
      end
      if (refill_done) begin
        miss_req = chain;
        if (chain) miss_addr = chain_addr;
      end else if (pulse_ignored && phase) begin
        miss_req  = (sent == 2);
        miss_addr = 32'h0000_1000;
      end
    end
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; miss_req = 1'b0; miss_addr = 32'h0; mem_arready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rlast = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, refill_done, mem_arvalid, mem_rready, ram_wen} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000", {busy, refill_done, mem_arvalid, mem_rready, ram_wen});
    end
    n_vec++;
    if ({mem_araddr, ram_addr, line_tag} !== 59'h0) begin
      n_err++; $display("FAIL reset_regs: got araddr=%h ram_addr=%h tag=%h want 0", mem_araddr, ram_addr, line_tag);
    end
    n_vec++;
    if (mem_arlen !== 8'd7) begin
      n_err++; $display("FAIL reset_arlen: got %0d want 7", mem_arlen);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    do_refill(32'h1FC0_0A64, 0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++; if (hs_araddr !== 32'h1FC0_0A60) begin n_err++; $display("FAIL basic_araddr: got %h want 1fc00a60", hs_araddr); end
    n_vec++; if (hs_arlen !== 8'd7) begin n_err++; $display("FAIL basic_arlen: got %0d want 7", hs_arlen); end
    n_vec++; if (wen_addr !== 7'h53) begin n_err++; $display("FAIL basic_idx: got %h want 53", wen_addr); end
    n_vec++; if (wen_tag !== 20'h1FC00) begin n_err++; $display("FAIL basic_tag: got %h want 1fc00", wen_tag); end
    n_vec++; if (wen_din !== exp_line) begin n_err++; $display("FAIL basic_line: got %h want %h", wen_din, exp_line); end
    n_vec++; if (wen_k !== 10) begin n_err++; $display("FAIL basic_wen_cycle: got %0d want 10", wen_k); end
    n_vec++; if (wen_done !== 1'b1 || done_count !== 1 || wen_count !== 1) begin
      n_err++; $display("FAIL basic_done: got done=%b dones=%0d wens=%0d want 1/1/1", wen_done, done_count, wen_count); end
    n_vec++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", busy_after); end
    n_vec++; if (handshakes + araddr_bad + arvalid_bad + rready_bad + busy_bad !== 1) begin
      n_err++; $display("FAIL basic_protocol: got hs=%0d ar=%0d av=%0d rr=%0d bz=%0d want 1/0/0/0/0",
                        handshakes, araddr_bad, arvalid_bad, rready_bad, busy_bad); end
  endtask

  task automatic test_addr_stall;
    logic [31:0] a;
    a = $urandom;
    do_refill(a, 5, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (wen_k !== 15) begin n_err++; $display("FAIL stall_wen_cycle: got %0d want 15", wen_k); end
    n_vec++; if (handshakes !== 1 || araddr_bad !== 0 || arvalid_bad !== 0) begin
      n_err++; $display("FAIL stall_addr_phase: got hs=%0d ar=%0d av=%0d want 1/0/0", handshakes, araddr_bad, arvalid_bad); end
    n_vec++; if (wen_din !== exp_line || wen_addr !== a[11:5]) begin
      n_err++; $display("FAIL stall_line: got idx=%h line=%h want idx=%h line=%h", wen_addr, wen_din, a[11:5], exp_line); end
  endtask

  task automatic test_data_bubbles;
    logic [31:0] a;
    a = $urandom;
    do_refill(a, 0, 1, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (wen_din !== exp_line) begin n_err++; $display("FAIL bubble_line: got %h want %h", wen_din, exp_line); end
    n_vec++; if (wen_count !== 1 || wen_k !== 16) begin
      n_err++; $display("FAIL bubble_wen: got count=%0d cycle=%0d want 1/16", wen_count, wen_k); end
    n_vec++; if (rready_bad !== 0) begin n_err++; $display("FAIL bubble_rready: got %0d drops want 0", rready_bad); end
  endtask

  task automatic test_ignored_req;
    logic [31:0] a;
    int          stray;
    a = {$urandom_range(1, 20'hFFFFF) , 7'h2A, 5'h04};
    do_refill(a, 1, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++; if (wen_addr !== 7'h2A || wen_tag !== a[31:12]) begin
      n_err++; $display("FAIL ignored_req_idx: got idx=%h tag=%h want 2a/%h", wen_addr, wen_tag, a[31:12]); end
    n_vec++; if (wen_din !== exp_line || wen_count !== 1) begin
      n_err++; $display("FAIL ignored_req_line: got %h (wens %0d) want %h", wen_din, wen_count, exp_line); end
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || mem_arvalid) stray++;
    end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL ignored_req_stray: got %0d busy cycles want 0", stray); end
  endtask

  task automatic test_reset_in_data;
    logic [31:0] a;
    int          wens, busys;
    a = $urandom | 32'h0000_0FE0;
    do_refill(a, 0, 0, 4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({busy, refill_done, mem_arvalid, mem_rready, ram_wen} !== 5'b0) begin
      n_err++; $display("FAIL rst_data_ctrl: got %b want 00000", {busy, refill_done, mem_arvalid, mem_rready, ram_wen});
    end
    n_vec++;
    if ({mem_araddr, ram_addr, line_tag} !== 59'h0) begin
      n_err++; $display("FAIL rst_data_regs: got araddr=%h ram_addr=%h tag=%h want 0", mem_araddr, ram_addr, line_tag);
    end
    reset = 1'b0;
    wens = (wen_count > 0) ? 1 : 0; busys = 0;
    repeat (12) begin
      @(negedge clk);
      if (ram_wen) wens++;
      if (busy) busys++;
    end
    n_vec++; if (wens !== 0 || busys !== 0) begin
      n_err++; $display("FAIL rst_data_nowrite: got wens=%0d busy=%0d want 0/0", wens, busys); end
    a = $urandom;
    do_refill(a, 2, 2, 0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (wen_din !== exp_line || wen_k !== 4 + data_cycles) begin
      n_err++; $display("FAIL rst_data_recover: got k=%0d line=%h want k=%0d line=%h", wen_k, wen_din, 4 + data_cycles, exp_line); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1, a2;
    logic [WORDS*32-1:0] line1;
    a1 = {$urandom_range(0, 20'hFFFFF), 7'h00, 5'($urandom_range(0, 31))};
    a2 = {$urandom_range(0, 20'hFFFFF), 7'h7F, 5'($urandom_range(0, 31))};
    do_refill(a1, 0, 0, 0, 1'b1, a2, 1'b0, 1'b0, 1'b0);
    line1 = exp_line;
    n_vec++; if (wen_addr !== 7'h00 || wen_tag !== a1[31:12] || wen_din !== line1) begin
      n_err++; $display("FAIL b2b_first: got idx=%h tag=%h want 00/%h", wen_addr, wen_tag, a1[31:12]); end
    n_vec++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy_after); end
    do_refill(a2, 0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (first_arvalid_k !== 1) begin n_err++; $display("FAIL b2b_start: got arvalid at %0d want 1", first_arvalid_k); end
    n_vec++; if (wen_addr !== 7'h7F || wen_tag !== a2[31:12] || wen_din !== exp_line || wen_k !== 10) begin
      n_err++; $display("FAIL b2b_second: got idx=%h tag=%h k=%0d want 7f/%h/10", wen_addr, wen_tag, wen_k, a2[31:12]); end
  endtask

  task automatic test_random;
    logic [31:0] a;
    int          st;
    for (int r = 0; r < 6; r++) begin
      a  = $urandom;
      st = $urandom_range(0, 3);
      do_refill(a, st, 2, 0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if (wen_din !== exp_line || wen_addr !== a[11:5] || wen_tag !== a[31:12] ||
          hs_araddr !== {a[31:5], 5'b0} || wen_count !== 1 || wen_k !== 2 + st + data_cycles) begin
        n_err++;
        $display("FAIL random_%0d: got idx=%h tag=%h base=%h k=%0d wens=%0d want idx=%h tag=%h base=%h k=%0d",
                 r, wen_addr, wen_tag, hs_araddr, wen_k, wen_count, a[11:5], a[31:12], {a[31:5], 5'b0},
                 2 + st + data_cycles);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_stall();
    test_data_bubbles();
    test_ignored_req();
    test_reset_in_data();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
